// File: rtl/tcm_dual_port_mem.sv
// Tightly-coupled memory: 64-bit fetch port plus 32-bit load/store port on one shared byte array.
// Both ports are always ready and respond one cycle after the request; array contents survive rst.

module tcm_dual_port_mem_ram #(
   parameter int WORDS = 16384,
   parameter int AW    = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_f_en,
   input  logic [AW-4:0] i_f_idx,
   output logic [63:0]   o_f_data,
   input  logic          i_d_rd_en,
   input  logic [7:0]    i_d_wr_be,
   input  logic [AW-4:0] i_d_idx,
   input  logic [63:0]   i_d_wdata,
   output logic [63:0]   o_d_data
);
   logic [63:0] ram [0:WORDS-1];
   logic [63:0] r_f_data;
   logic [63:0] r_d_data;

   // Byte-strobed store; the array itself is never reset
   always @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (i_d_wr_be[b]) begin
            ram[i_d_idx][8*b +: 8] <= i_d_wdata[8*b +: 8];
         end
      end
   end

   // Read-first registered reads: a same-edge store is not visible until the next read
   always_ff @(posedge clk) begin
      if (rst) begin
         r_f_data <= 64'd0;
         r_d_data <= 64'd0;
      end else begin
         if (i_f_en) begin
            r_f_data <= ram[i_f_idx];
         end
         if (i_d_rd_en) begin
            r_d_data <= ram[i_d_idx];
         end
      end
   end

   assign o_f_data = r_f_data;
   assign o_d_data = r_d_data;

   // Backdoor preload of one byte, intended for image loading from a testbench
   task write(input logic [31:0] addr, input logic [7:0] data);
      ram[addr[AW-1:3]][{addr[2:0], 3'b000} +: 8] <= data;
   endtask
endmodule

module tcm_dual_port_mem #(
   parameter int SIZE_BYTES = 131072,
   parameter int AW         = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_i_rd_i,
   input  logic        mem_i_flush_i,
   input  logic        mem_i_invalidate_i,
   input  logic [31:0] mem_i_pc_i,
   output logic        mem_i_accept_o,
   output logic        mem_i_valid_o,
   output logic        mem_i_error_o,
   output logic [63:0] mem_i_inst_o,
   input  logic [31:0] mem_d_addr_i,
   input  logic [31:0] mem_d_data_wr_i,
   input  logic        mem_d_rd_i,
   input  logic [3:0]  mem_d_wr_i,
   input  logic        mem_d_cacheable_i,
   input  logic [10:0] mem_d_req_tag_i,
   input  logic        mem_d_invalidate_i,
   input  logic        mem_d_writeback_i,
   input  logic        mem_d_flush_i,
   output logic        mem_d_accept_o,
   output logic        mem_d_ack_o,
   output logic        mem_d_error_o,
   output logic [10:0] mem_d_resp_tag_o,
   output logic [31:0] mem_d_data_rd_o
);
   localparam int WORDS = SIZE_BYTES / 8;

   logic        w_d_req;
   logic [7:0]  w_wr_be;
   logic [63:0] w_d_word;
   logic        w_unused;
   logic        r_valid;
   logic        r_ack;
   logic [10:0] r_tag;
   logic        r_half;

   assign w_d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i;
   // Strobes steered onto the addressed half; stores are suppressed during reset
   assign w_wr_be = rst ? 8'h00 : (mem_d_addr_i[2] ? {mem_d_wr_i, 4'h0} : {4'h0, mem_d_wr_i});
   assign w_unused = ^{mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i[31:AW], mem_i_pc_i[2:0],
                       mem_d_addr_i[31:AW], mem_d_addr_i[1:0], mem_d_cacheable_i};

   tcm_dual_port_mem_ram #(.WORDS(WORDS), .AW(AW)) u_ram (
      .clk       (clk),
      .rst       (rst),
      .i_f_en    (mem_i_rd_i),
      .i_f_idx   (mem_i_pc_i[AW-1:3]),
      .o_f_data  (mem_i_inst_o),
      .i_d_rd_en (mem_d_rd_i),
      .i_d_wr_be (w_wr_be),
      .i_d_idx   (mem_d_addr_i[AW-1:3]),
      .i_d_wdata ({mem_d_data_wr_i, mem_d_data_wr_i}),
      .o_d_data  (w_d_word)
   );

   // Response strobes, tag capture and load half-select
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ack   <= 1'b0;
         r_tag   <= 11'd0;
         r_half  <= 1'b0;
      end else begin
         r_valid <= mem_i_rd_i;
         r_ack   <= w_d_req;
         if (w_d_req) begin
            r_tag <= mem_d_req_tag_i;
         end
         if (mem_d_rd_i) begin
            r_half <= mem_d_addr_i[2];
         end
      end
   end

   assign mem_i_accept_o   = 1'b1;
   assign mem_i_error_o    = 1'b0;
   assign mem_i_valid_o    = r_valid;
   assign mem_d_accept_o   = 1'b1;
   assign mem_d_error_o    = 1'b0;
   assign mem_d_ack_o      = r_ack;
   assign mem_d_resp_tag_o = r_tag;
   assign mem_d_data_rd_o  = r_half ? w_d_word[63:32] : w_d_word[31:0];
endmodule

// File: tb/tb_tcm_dual_port_mem.sv
// Directed self-checking bench for tcm_dual_port_mem with hand-computed expectations.

module tb_tcm_dual_port_mem;
   logic        clk = 1'b0;
   logic        rst;
   logic        i_rd, i_flush, i_inv;
   logic [31:0] i_pc;
   logic        i_accept, i_valid, i_error;
   logic [63:0] i_inst;
   logic [31:0] d_addr, d_wdata;
   logic        d_rd;
   logic [3:0]  d_wr;
   logic        d_cache;
   logic [10:0] d_tag;
   logic        d_inv, d_wb, d_flush;
   logic        d_accept, d_ack, d_error;
   logic [10:0] d_rtag;
   logic [31:0] d_rdata;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   tcm_dual_port_mem dut (
      .clk(clk), .rst(rst),
      .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush), .mem_i_invalidate_i(i_inv), .mem_i_pc_i(i_pc),
      .mem_i_accept_o(i_accept), .mem_i_valid_o(i_valid), .mem_i_error_o(i_error), .mem_i_inst_o(i_inst),
      .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr),
      .mem_d_cacheable_i(d_cache), .mem_d_req_tag_i(d_tag), .mem_d_invalidate_i(d_inv),
      .mem_d_writeback_i(d_wb), .mem_d_flush_i(d_flush),
      .mem_d_accept_o(d_accept), .mem_d_ack_o(d_ack), .mem_d_error_o(d_error),
      .mem_d_resp_tag_o(d_rtag), .mem_d_data_rd_o(d_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      i_rd = 1'b0; i_flush = 1'b0; i_inv = 1'b0; i_pc = 32'd0;
      d_addr = 32'd0; d_wdata = 32'd0; d_rd = 1'b0; d_wr = 4'd0; d_cache = 1'b0;
      d_tag = 11'd0; d_inv = 1'b0; d_wb = 1'b0; d_flush = 1'b0;
   endtask

   // Advance one rising edge and settle 1 ns after it
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      i_rd = 1'b1; d_rd = 1'b1; d_tag = 11'h123;
      cyc(); cyc();
      chk("rst_valid", {63'd0, i_valid}, 64'd0);
      chk("rst_ack", {63'd0, d_ack}, 64'd0);
      chk("rst_tag", {53'd0, d_rtag}, 64'd0);
      chk("rst_inst", i_inst, 64'd0);
      chk("rst_rdata", {32'd0, d_rdata}, 64'd0);
      chk("rst_const", {60'd0, i_accept, i_error, d_accept, d_error}, 64'ha);

      // Release reset with no request: nothing from the reset-time requests may surface
      rst = 1'b0; idle();
      cyc();
      chk("post_rst_ack", {63'd0, d_ack}, 64'd0);
      chk("post_rst_valid", {63'd0, i_valid}, 64'd0);

      // Backdoor preload: bytes 0..7, plus zeroed words used below
      for (int k = 0; k < 8; k++) dut.u_ram.write(k, 8'(k));
      for (int k = 0; k < 8; k++) dut.u_ram.write(32'h10 + k, 8'h00);
      for (int k = 0; k < 8; k++) dut.u_ram.write(32'h18000 + k, 8'h00);
      #1;
      i_rd = 1'b1; i_pc = 32'h8000_0000;
      cyc();
      chk("fetch_valid", {63'd0, i_valid}, 64'd1);
      chk("fetch_inst", i_inst, 64'h0706050403020100);
      idle();
      cyc();
      chk("fetch_idle_valid", {63'd0, i_valid}, 64'd0);
      chk("fetch_hold_inst", i_inst, 64'h0706050403020100);

      // Partial store into upper half of word 0x3000, then load it back
      d_addr = 32'h8001_8004; d_wdata = 32'hDEAD_BEEF; d_wr = 4'b0011; d_tag = 11'h155;
      cyc();
      chk("st_ack", {63'd0, d_ack}, 64'd1);
      chk("st_tag", {53'd0, d_rtag}, 64'h155);
      idle();
      d_addr = 32'h8001_8004; d_rd = 1'b1; d_tag = 11'h0AA;
      cyc();
      chk("ld_ack_b2b", {63'd0, d_ack}, 64'd1);
      chk("ld_tag", {53'd0, d_rtag}, 64'h0AA);
      chk("ld_beef", {32'd0, d_rdata}, 64'h0000_BEEF);

      // Aliasing: upper address bits ignored
      idle();
      d_addr = 32'h8000_0010; d_wdata = 32'h1234_5678; d_wr = 4'hF; d_tag = 11'h001;
      cyc();
      idle();
      d_addr = 32'h0002_0010; d_rd = 1'b1; d_tag = 11'h002;
      cyc();
      chk("alias_ld", {32'd0, d_rdata}, 64'h1234_5678);

      // Same-cycle store+load+fetch to one word: reads see old data
      idle();
      d_addr = 32'h10; d_wdata = 32'hCAFE_F00D; d_wr = 4'hF; d_rd = 1'b1; d_tag = 11'h003;
      i_rd = 1'b1; i_pc = 32'h10;
      cyc();
      chk("rw_old", {32'd0, d_rdata}, 64'h1234_5678);
      chk("rw_fetch_old", i_inst, 64'h0000_0000_1234_5678);
      idle();
      d_addr = 32'h10; d_rd = 1'b1; d_tag = 11'h004;
      cyc();
      chk("rw_new", {32'd0, d_rdata}, 64'hCAFE_F00D);

      // Strobes 1010 on upper half: bytes 5 and 7 only
      idle();
      d_addr = 32'h14; d_wdata = 32'hA1B2_C3D4; d_wr = 4'b1010; d_tag = 11'h005;
      cyc();
      idle();
      d_addr = 32'h14; d_rd = 1'b1; d_tag = 11'h006;
      cyc();
      chk("strobe_ld", {32'd0, d_rdata}, 64'hA100_C300);
      idle();
      i_rd = 1'b1; i_pc = 32'h10;
      cyc();
      chk("strobe_fetch", i_inst, 64'hA100_C300_CAFE_F00D);
      chk("idle_ack", {63'd0, d_ack}, 64'd0);

      // Maintenance requests ack with their tag and leave memory alone
      idle();
      d_flush = 1'b1; d_tag = 11'h7FF; d_addr = 32'h10; d_wdata = 32'hFFFF_FFFF;
      cyc();
      chk("flush_ack", {63'd0, d_ack}, 64'd1);
      chk("flush_tag", {53'd0, d_rtag}, 64'h7FF);
      idle();
      d_inv = 1'b1; d_tag = 11'h011;
      cyc();
      chk("inv_tag", {53'd0, d_rtag}, 64'h011);
      idle();
      d_wb = 1'b1; d_tag = 11'h022;
      cyc();
      chk("wb_tag", {53'd0, d_rtag}, 64'h022);
      idle();
      d_addr = 32'h10; d_rd = 1'b1; d_tag = 11'h033;
      cyc();
      chk("flush_mem_same", {32'd0, d_rdata}, 64'hCAFE_F00D);

      // Reset mid-stream with fetch, load and store active
      rst = 1'b1;
      i_rd = 1'b1; i_pc = 32'h0; d_rd = 1'b1; d_wr = 4'hF; d_addr = 32'h10; d_wdata = 32'hFFFF_FFFF;
      cyc();
      chk("mrst_ack", {63'd0, d_ack}, 64'd0);
      chk("mrst_valid", {63'd0, i_valid}, 64'd0);
      chk("mrst_inst", i_inst, 64'd0);
      rst = 1'b0; idle();
      d_addr = 32'h10; d_rd = 1'b1; d_tag = 11'h044;
      i_rd = 1'b1; i_pc = 32'h0;
      cyc();
      chk("mrst_keep_d", {32'd0, d_rdata}, 64'hCAFE_F00D);
      chk("mrst_keep_i", i_inst, 64'h0706050403020100);
      chk("mrst_tag", {53'd0, d_rtag}, 64'h044);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
